// File: rtl/blackparrot_fpga_host_csr.sv
// AXI4-Lite register file bridging host software to the BlackParrot MMIO host FIFOs.
// Independent single-outstanding read and write FSMs; also owns the BP reset bit.
module blackparrot_fpga_host_csr #(
  parameter int S_AXIL_ADDR_WIDTH = 32,
  parameter int S_AXIL_DATA_WIDTH = 32,
  parameter int fifo_data_width_p = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [S_AXIL_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [3:0]                   s_axil_wstrb,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  output logic [1:0]                   s_axil_bresp,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  output logic [S_AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]                   s_axil_rresp,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  input  logic                         mmio_req_v_i,
  input  logic [fifo_data_width_p-1:0] mmio_req_data_i,
  output logic                         mmio_req_yumi_o,
  input  logic                         mmio_count_v_i,
  input  logic [fifo_data_width_p-1:0] mmio_count_i,
  output logic                         mmio_count_yumi_o,
  output logic                         mmio_resp_v_o,
  output logic [fifo_data_width_p-1:0] mmio_resp_data_o,
  input  logic                         mmio_resp_ready_and_i,
  output logic                         bp_reset_o
);
  localparam int DW = S_AXIL_DATA_WIDTH;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;

  rstate_t       r_rstate;
  wstate_t       r_wstate;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_rresp;
  logic          r_aw_held, r_w_held;
  logic [3:0]    r_awidx;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_wstrb;
  logic [1:0]    r_bresp;
  logic          r_bp_reset;

  logic          w_ar_hs, w_aw_hs, w_w_hs;
  logic [3:0]    w_aridx;
  logic [DW-1:0] w_rdata_next;
  logic [1:0]    w_rresp_next, w_bresp_next;
  logic          w_req_pop, w_cnt_pop;
  logic          w_unused;

  assign w_unused = &{1'b0, s_axil_araddr[S_AXIL_ADDR_WIDTH-1:6], s_axil_araddr[1:0],
                      s_axil_awaddr[S_AXIL_ADDR_WIDTH-1:6], s_axil_awaddr[1:0]};

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign s_axil_arready = (r_rstate == R_IDLE) & ~reset;
  assign s_axil_rvalid  = (r_rstate == R_RESP);
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign w_ar_hs        = s_axil_arvalid & s_axil_arready;
  assign w_aridx        = s_axil_araddr[5:2];

  always_comb begin
    w_rdata_next = '0;
    w_rresp_next = OKAY;
    w_req_pop    = 1'b0;
    w_cnt_pop    = 1'b0;
    case (w_aridx)
      4'd0: if (mmio_req_v_i) begin
              w_rdata_next = mmio_req_data_i;
              w_req_pop    = 1'b1;
            end else w_rresp_next = SLVERR;
      4'd1: if (mmio_count_v_i) begin
              w_rdata_next = mmio_count_i;
              w_cnt_pop    = 1'b1;
            end else w_rresp_next = SLVERR;
      4'd2: w_rdata_next = '0;
      4'd3: w_rdata_next = {{(DW-1){1'b0}}, r_bp_reset};
      4'd4: w_rdata_next = {{(DW-3){1'b0}}, r_bp_reset, mmio_resp_ready_and_i, mmio_req_v_i};
      default: w_rresp_next = DECERR;
    endcase
  end

  assign mmio_req_yumi_o   = w_ar_hs & w_req_pop;
  assign mmio_count_yumi_o = w_ar_hs & w_cnt_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: if (w_ar_hs) begin
                  r_rdata  <= w_rdata_next;
                  r_rresp  <= w_rresp_next;
                  r_rstate <= R_RESP;
                end
        R_RESP: if (s_axil_rready) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axil_awready   = (r_wstate == W_IDLE) & ~r_aw_held & ~reset;
  assign s_axil_wready    = (r_wstate == W_IDLE) & ~r_w_held & ~reset;
  assign w_aw_hs          = s_axil_awvalid & s_axil_awready;
  assign w_w_hs           = s_axil_wvalid & s_axil_wready;
  assign s_axil_bvalid    = (r_wstate == W_RESP);
  assign s_axil_bresp     = r_bresp;
  assign bp_reset_o       = r_bp_reset;
  assign mmio_resp_data_o = r_wdata;
  assign mmio_resp_v_o    = (r_wstate == W_EXEC) & (r_awidx == 4'd2) & (r_wstrb == 4'hF);

  always_comb begin
    w_bresp_next = OKAY;
    case (r_awidx)
      4'd0, 4'd1, 4'd3, 4'd4: w_bresp_next = OKAY;
      4'd2: w_bresp_next = ((r_wstrb == 4'hF) && mmio_resp_ready_and_i) ? OKAY : SLVERR;
      default: w_bresp_next = DECERR;
    endcase
  end

  // Entering W_EXEC on the completing handshake itself keeps write latency at two cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate   <= W_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awidx    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= OKAY;
      r_bp_reset <= 1'b1;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awidx   <= s_axil_awaddr[5:2];
          end
          if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axil_wdata;
            r_wstrb  <= s_axil_wstrb;
          end
          if ((r_aw_held | w_aw_hs) & (r_w_held | w_w_hs)) r_wstate <= W_EXEC;
        end
        W_EXEC: begin
          r_bresp <= w_bresp_next;
          if (r_awidx == 4'd3 && r_wstrb[0]) r_bp_reset <= r_wdata[0];
          r_aw_held <= 1'b0;
          r_w_held  <= 1'b0;
          r_wstate  <= W_RESP;
        end
        W_RESP: if (s_axil_bready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blackparrot_fpga_host_csr.sv
// Bench for blackparrot_fpga_host_csr: directed scenarios plus randomized traffic
// checked against a queue-based model of the register map and MMIO FIFOs.
module tb_blackparrot_fpga_host_csr;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [3:0]  s_axil_wstrb;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;
  logic        mmio_req_v_i, mmio_req_yumi_o, mmio_count_v_i, mmio_count_yumi_o;
  logic [31:0] mmio_req_data_i, mmio_count_i, mmio_resp_data_o;
  logic        mmio_resp_v_o, mmio_resp_ready_and_i, bp_reset_o;

  always #5 clk = ~clk;

  blackparrot_fpga_host_csr dut (
    .clk(clk), .reset(reset),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .mmio_req_v_i(mmio_req_v_i), .mmio_req_data_i(mmio_req_data_i), .mmio_req_yumi_o(mmio_req_yumi_o),
    .mmio_count_v_i(mmio_count_v_i), .mmio_count_i(mmio_count_i), .mmio_count_yumi_o(mmio_count_yumi_o),
    .mmio_resp_v_o(mmio_resp_v_o), .mmio_resp_data_o(mmio_resp_data_o),
    .mmio_resp_ready_and_i(mmio_resp_ready_and_i), .bp_reset_o(bp_reset_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] req_q[$];
  logic [31:0] exp_push_q[$];
  logic [31:0] obs_push_q[$];
  logic        model_bp_reset = 1'b1;
  int          exp_req_pops = 0, exp_cnt_pops = 0;
  int          req_pops_obs = 0, cnt_pops_obs = 0, resp_v_cycles = 0;
  bit          pop_pending = 0;

  function automatic void refresh_req();
    mmio_req_v_i    = (req_q.size() != 0);
    mmio_req_data_i = (req_q.size() != 0) ? req_q[0] : 32'hBAD0BAD0;
  endfunction

  always @(negedge clk) begin
    if (mmio_req_yumi_o) begin
      req_pops_obs++;
      pop_pending = 1;
    end
    if (mmio_count_yumi_o) cnt_pops_obs++;
    if (mmio_resp_v_o) resp_v_cycles++;
    if (mmio_resp_v_o && mmio_resp_ready_and_i) obs_push_q.push_back(mmio_resp_data_o);
  end

  always @(posedge clk) begin
    #1;
    if (pop_pending && req_q.size() != 0) void'(req_q.pop_front());
    pop_pending = 0;
    refresh_req();
  end

  task automatic model_read(input logic [3:0] idx, output logic [31:0] d, output logic [1:0] r,
                            output bit pr, output bit pc);
    d = 32'h0; r = 2'b00; pr = 0; pc = 0;
    case (idx)
      4'd0: if (req_q.size() != 0) begin d = req_q[0]; pr = 1; end else r = 2'b10;
      4'd1: if (mmio_count_v_i) begin d = mmio_count_i; pc = 1; end else r = 2'b10;
      4'd2: d = 32'h0;
      4'd3: d = {31'h0, model_bp_reset};
      4'd4: d = {29'h0, model_bp_reset, mmio_resp_ready_and_i, req_q.size() != 0};
      default: r = 2'b11;
    endcase
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold, input string tag);
    logic [31:0] ed;
    logic [1:0]  er;
    bit pr, pc, ok;
    int c;
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    s_axil_rready  = (hold == 0);
    ok = 0; c = 0; ed = 0; er = 0; pr = 0; pc = 0;
    while (!ok && c < 20) begin
      @(negedge clk);
      if (s_axil_arready) begin
        ok = 1;
        model_read(addr[5:2], ed, er, pr, pc);
        check_val({tag, ".req_yumi"}, {31'h0, mmio_req_yumi_o}, {31'h0, pr});
        check_val({tag, ".cnt_yumi"}, {31'h0, mmio_count_yumi_o}, {31'h0, pc});
      end
      @(posedge clk); #1;
      c++;
    end
    s_axil_arvalid = 1'b0;
    if (!ok) begin
      check_val({tag, ".ar_timeout"}, 32'h0, 32'h1);
      s_axil_rready = 1'b0;
      return;
    end
    if (pr) exp_req_pops++;
    if (pc) exp_cnt_pops++;
    @(negedge clk);
    check_val({tag, ".rvalid_lat"}, {31'h0, s_axil_rvalid}, 32'h1);
    check_val({tag, ".rdata"}, s_axil_rdata, ed);
    check_val({tag, ".rresp"}, {30'h0, s_axil_rresp}, {30'h0, er});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_val({tag, ".hold_rvalid"}, {31'h0, s_axil_rvalid}, 32'h1);
      check_val({tag, ".hold_rdata"}, s_axil_rdata, ed);
      check_val({tag, ".hold_arready"}, {31'h0, s_axil_arready}, 32'h0);
    end
    s_axil_rready = 1'b1;
    @(posedge clk); #1;
    s_axil_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_start, input int w_start, input string tag);
    bit aw_done, w_done, awh, wh;
    logic [1:0] eb;
    int c;
    aw_done = 0; w_done = 0; c = 0;
    s_axil_awaddr = addr;
    s_axil_wdata  = data;
    s_axil_wstrb  = strb;
    while (!(aw_done && w_done) && c < 30) begin
      s_axil_awvalid = !aw_done && (c >= aw_start);
      s_axil_wvalid  = !w_done && (c >= w_start);
      @(negedge clk);
      awh = s_axil_awvalid && s_axil_awready;
      wh  = s_axil_wvalid && s_axil_wready;
      @(posedge clk); #1;
      if (awh) aw_done = 1;
      if (wh) w_done = 1;
      c++;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check_val({tag, ".aw_w_timeout"}, 32'h0, 32'h1);
      return;
    end
    eb = 2'b00;
    case (addr[5:2])
      4'd2: if (strb == 4'hF && mmio_resp_ready_and_i) exp_push_q.push_back(data); else eb = 2'b10;
      4'd3: if (strb[0]) model_bp_reset = data[0];
      4'd0, 4'd1, 4'd4: eb = 2'b00;
      default: eb = 2'b11;
    endcase
    @(negedge clk);
    check_val({tag, ".bvalid_exec"}, {31'h0, s_axil_bvalid}, 32'h0);
    @(posedge clk); #1;
    c = 0;
    @(negedge clk);
    check_val({tag, ".bvalid_lat"}, {31'h0, s_axil_bvalid}, 32'h1);
    while (!s_axil_bvalid && c < 10) begin
      @(negedge clk);
      c++;
    end
    check_val({tag, ".bresp"}, {30'h0, s_axil_bresp}, {30'h0, eb});
    @(posedge clk); #1;
    check_val({tag, ".bp_reset"}, {31'h0, bp_reset_o}, {31'h0, model_bp_reset});
  endtask

  initial begin
    int v0;
    logic [31:0] rnd, a;
    logic [3:0]  idx, st;
    reset = 1'b1;
    s_axil_awaddr = 0; s_axil_awvalid = 0; s_axil_wdata = 0; s_axil_wstrb = 0; s_axil_wvalid = 0;
    s_axil_bready = 1'b1; s_axil_araddr = 0; s_axil_arvalid = 0; s_axil_rready = 0;
    mmio_count_v_i = 0; mmio_count_i = 0; mmio_resp_ready_and_i = 1'b1;
    refresh_req();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst.arready", {31'h0, s_axil_arready}, 32'h0);
    check_val("rst.awready", {31'h0, s_axil_awready}, 32'h0);
    check_val("rst.wready", {31'h0, s_axil_wready}, 32'h0);
    check_val("rst.rvalid", {31'h0, s_axil_rvalid}, 32'h0);
    check_val("rst.bvalid", {31'h0, s_axil_bvalid}, 32'h0);
    check_val("rst.rdata", s_axil_rdata, 32'h0);
    check_val("rst.resps", {28'h0, s_axil_rresp, s_axil_bresp}, 32'h0);
    check_val("rst.resp_v", {31'h0, mmio_resp_v_o}, 32'h0);
    check_val("rst.bp_reset", {31'h0, bp_reset_o}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst.readies", {29'h0, s_axil_arready, s_axil_awready, s_axil_wready}, 32'h7);
    check_val("post_rst.bp_reset", {31'h0, bp_reset_o}, 32'h1);
    @(posedge clk); #1;

    axi_write(32'h0C, 32'h0, 4'hF, 0, 0, "ctrl_clr");
    axi_read(32'h0C, 0, "ctrl_rd");

    req_q.push_back(32'h80001000);
    req_q.push_back(32'h000000AB);
    refresh_req();
    axi_read(32'h00, 0, "pop1");
    axi_read(32'h00, 0, "pop2");
    axi_read(32'h00, 0, "pop_empty");
    check_val("pop.count", req_pops_obs, exp_req_pops);

    mmio_count_v_i = 1'b1; mmio_count_i = 32'd2;
    axi_read(32'h04, 0, "count");
    check_val("count.pulses", cnt_pops_obs, exp_cnt_pops);

    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 3, 0, "push_ok");
    mmio_resp_ready_and_i = 1'b0;
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 3, 0, "push_full");
    mmio_resp_ready_and_i = 1'b1;
    v0 = resp_v_cycles;
    axi_write(32'h08, 32'hDEADBEEF, 4'h3, 3, 0, "push_strb");
    check_val("push_strb.resp_v", resp_v_cycles, v0);
    check_val("push.n", obs_push_q.size(), exp_push_q.size());

    req_q.push_back(32'hCAFE0001);
    refresh_req();
    fork
      axi_read(32'h00, 5, "conc_rd");
      axi_write(32'h08, 32'h12345678, 4'hF, 0, 0, "conc_wr");
    join

    axi_read(32'h20, 0, "decerr_rd");
    axi_write(32'h3C, 32'hFFFFFFFF, 4'hF, 0, 0, "decerr_wr");
    axi_read(32'hFFFFFFC4, 0, "hi_bits_rd");

    // Abort: AW held, then reset lands before W completes the pair.
    v0 = resp_v_cycles;
    s_axil_awaddr = 32'h08; s_axil_awvalid = 1'b1;
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0;
    s_axil_wdata = 32'h55AA55AA; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s_axil_wvalid = 1'b0;
    reset = 1'b0;
    model_bp_reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check_val("abort.resp_v", resp_v_cycles, v0);
    check_val("abort.bp_reset", {31'h0, bp_reset_o}, 32'h1);
    check_val("abort.idle", {28'h0, s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready}, 32'hD);
    @(posedge clk); #1;

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        req_q.push_back($urandom);
        refresh_req();
      end
      mmio_count_v_i = 1'($urandom_range(0, 1));
      mmio_count_i = $urandom;
      mmio_resp_ready_and_i = 1'($urandom_range(0, 1));
      rnd = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        idx = 4'($urandom_range(0, 15));
        a = {rnd[31:6], idx, rnd[1:0]};
        axi_read(a, $urandom_range(0, 2), "rnd_rd");
      end else begin
        idx = 4'($urandom_range(2, 15));
        a = {rnd[31:6], idx, rnd[1:0]};
        st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        axi_write(a, $urandom, st, $urandom_range(0, 3), $urandom_range(0, 3), "rnd_wr");
      end
    end

    check_val("final.req_pops", req_pops_obs, exp_req_pops);
    check_val("final.cnt_pops", cnt_pops_obs, exp_cnt_pops);
    check_val("final.push_n", obs_push_q.size(), exp_push_q.size());
    for (int i = 0; i < exp_push_q.size() && i < obs_push_q.size(); i++)
      check_val("final.push_data", obs_push_q[i], exp_push_q[i]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
